// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin arbiter sharing one cordic_magphase core
module cordic_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = 2,
    parameter int INPUT_WIDTH    = 16,
    parameter int INT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_y,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [INT_WIDTH-1:0]           rsp_mag,
    output logic [INT_WIDTH-1:0]           rsp_phase,
    output logic                           rsp_err,
    output logic                           core_start,
    output logic [INPUT_WIDTH-1:0]         core_x,
    output logic [INPUT_WIDTH-1:0]         core_y,
    input  logic                           core_busy,
    input  logic                           core_done,
    input  logic [INT_WIDTH-1:0]           core_mag,
    input  logic [INT_WIDTH-1:0]           core_phase,
    output logic                           arb_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    last_grant_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [INPUT_WIDTH-1:0] x_q, y_q;
    logic [15:0]            cnt_q;
    logic                   rsp_valid_q, rsp_err_q;
    logic [INT_WIDTH-1:0]   rsp_mag_q, rsp_phase_q;

    logic                   win_found;
    logic [ID_WIDTH-1:0]    win_idx;
    logic [INPUT_WIDTH-1:0] win_x, win_y;
    logic                   grant_fire, wait_done, wait_timeout, resp_fire;
    logic                   timeout_hit;

    assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Round-robin pick: lowest valid index above last_grant, else lowest valid index (wrap).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = ID_WIDTH'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_WIDTH'(i) > last_grant_q)) begin
                win_idx = ID_WIDTH'(i);
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        win_x = '0;
        win_y = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_WIDTH'(i)) begin
                win_x = req_x[i*INPUT_WIDTH +: INPUT_WIDTH];
                win_y = req_y[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, one-hot grant, core start and datapath strobes.
    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        core_start   = 1'b0;
        grant_fire   = 1'b0;
        wait_done    = 1'b0;
        wait_timeout = 1'b0;
        resp_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (win_idx == ID_WIDTH'(i));
                    end
                    grant_fire = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // A busy core holds the request here without pulsing start.
                if (!core_busy) begin
                    core_start = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle takes precedence.
                if (core_done) begin
                    wait_done = 1'b1;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    wait_timeout = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, timeout counter, response registers and grant history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            id_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_mag_q    <= '0;
            rsp_phase_q  <= '0;
        end else begin
            if (grant_fire) begin
                x_q  <= win_x;
                y_q  <= win_y;
                id_q <= win_idx;
            end
            if (core_start) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (wait_done) begin
                rsp_mag_q   <= core_mag;
                rsp_phase_q <= core_phase;
                rsp_err_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
            end else if (wait_timeout) begin
                rsp_mag_q   <= '0;
                rsp_phase_q <= '0;
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
            end
            if (resp_fire) begin
                rsp_valid_q  <= 1'b0;
                last_grant_q <= id_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_mag   = rsp_mag_q;
    assign rsp_phase = rsp_phase_q;
    assign rsp_err   = rsp_err_q;
    assign core_x    = x_q;
    assign core_y    = y_q;
    assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - scoreboard testbench for cordic_arbiter
`timescale 1ns/1ps
module tb_cordic_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int ID_WIDTH       = 2;
    localparam int INPUT_WIDTH    = 16;
    localparam int INT_WIDTH      = 32;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int RW             = ID_WIDTH + 1 + 2 * INT_WIDTH;
    typedef logic [RW-1:0] rsp_t;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_x, req_y;
    logic                           rsp_valid, rsp_ready;
    logic [ID_WIDTH-1:0]            rsp_id;
    logic [INT_WIDTH-1:0]           rsp_mag, rsp_phase;
    logic                           rsp_err;
    logic                           core_start;
    logic [INPUT_WIDTH-1:0]         core_x, core_y;
    logic                           core_busy;
    logic                           core_done = 1'b0;
    logic [INT_WIDTH-1:0]           core_mag = '0;
    logic [INT_WIDTH-1:0]           core_phase = '0;
    logic                           arb_busy;

    int checks = 0;
    int failures = 0;
    rsp_t sb[$];

    int core_lat = 0;
    logic [31:0] model_mag = '0;
    logic [31:0] model_phase = '0;
    int cd = 0;
    int n_start = 0;
    int cyc_cnt = 0;
    int grant_cyc = 0;

    cordic_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .INPUT_WIDTH(INPUT_WIDTH),
        .INT_WIDTH(INT_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_mag(rsp_mag), .rsp_phase(rsp_phase), .rsp_err(rsp_err),
        .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_busy(core_busy), .core_done(core_done),
        .core_mag(core_mag), .core_phase(core_phase), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    // Core model: done pulses core_lat cycles after start (core_lat=0 never answers).
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (core_start) begin
            n_start <= n_start + 1;
            cd = core_lat;
        end else if (cd > 0) begin
            cd = cd - 1;
        end
        core_done <= (cd == 1);
        if (cd == 1) begin
            core_mag   <= model_mag;
            core_phase <= model_phase;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_grant(output logic [NUM_REQ-1:0] rr, output bit ok);
        ok = 1'b0;
        rr = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                rr = req_ready;
                grant_cyc = cyc_cnt;
            end
        end
    endtask

    task automatic wait_rsp(output rsp_t got, output int lat, output bit ok);
        ok = 1'b0;
        got = '0;
        lat = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                ok = 1'b1;
                got = {rsp_id, rsp_err, rsp_mag, rsp_phase};
                lat = cyc_cnt - grant_cyc;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({rsp_valid, rsp_err, rsp_id, rsp_mag, rsp_phase} !== '0) begin
            failures++;
            $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_id, rsp_mag, rsp_phase});
        end
        checks++;
        if ({core_start, core_x, core_y, arb_busy, req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_core got=%h exp=0", {core_start, core_x, core_y, arb_busy, req_ready});
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_winner got=%b exp=0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] rr;
        bit ok;
        rsp_t got, exp;
        int lat, s0;
        core_lat = 34;
        model_mag = 32'd5;
        model_phase = 32'h0ED63383;
        @(negedge clk);
        req_x = '0;
        req_y = '0;
        req_x[15:0] = 16'd3;
        req_y[15:0] = 16'd4;
        req_valid = 4'b0001;
        s0 = n_start;
        sb.push_back({2'd0, 1'b0, 32'd5, 32'h0ED63383});
        wait_grant(rr, ok);
        checks++;
        if (!ok || rr !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant got=%b exp=0001", rr);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({core_start, arb_busy, core_x, core_y} !== {1'b1, 1'b1, 16'd3, 16'd4}) begin
            failures++;
            $display("FAIL single_issue got=%h exp=%h", {core_start, arb_busy, core_x, core_y},
                     {1'b1, 1'b1, 16'd3, 16'd4});
        end
        wait_rsp(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL single_rsp got=%h exp=%h", got, exp);
        end
        checks++;
        if (lat !== 36) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=36", lat);
        end
        checks++;
        if (n_start - s0 !== 1) begin
            failures++;
            $display("FAIL single_start_count got=%0d exp=1", n_start - s0);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] rr;
        bit ok;
        rsp_t got, exp;
        int lat, e;
        apply_reset();
        core_lat = 3;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_x[i*INPUT_WIDTH +: INPUT_WIDTH] = 16'(100 + i);
            req_y[i*INPUT_WIDTH +: INPUT_WIDTH] = 16'(200 + i);
        end
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            e = g % NUM_REQ;
            model_mag = 32'(1000 + g);
            model_phase = 32'(g);
            wait_grant(rr, ok);
            checks++;
            if (!ok || rr !== 4'(1 << e)) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", g, rr, 4'(1 << e));
            end
            sb.push_back({ID_WIDTH'(e), 1'b0, 32'(1000 + g), 32'(g)});
            @(negedge clk);
            #1;
            checks++;
            if ({core_x, core_y} !== {16'(100 + e), 16'(200 + e)}) begin
                failures++;
                $display("FAIL rr_operands[%0d] got=%h exp=%h", g, {core_x, core_y},
                         {16'(100 + e), 16'(200 + e)});
            end
            wait_rsp(got, lat, ok);
            checks++;
            if (!ok || req_ready !== '0) begin
                failures++;
                $display("FAIL rr_no_grant_in_resp[%0d] got=%b exp=0000", g, req_ready);
            end
            if (g == 4) req_valid = '0;
            exp = sb.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL rr_rsp[%0d] got=%h exp=%h", g, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NUM_REQ-1:0] rr;
        bit ok;
        rsp_t got, exp;
        int lat, s0;
        core_lat = 6;
        model_mag = 32'h1234_5678;
        model_phase = 32'hF000_0001;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        sb.push_back({2'd2, 1'b0, 32'h1234_5678, 32'hF000_0001});
        wait_grant(rr, ok);
        checks++;
        if (!ok || rr !== 4'b0100) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=0100", rr);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        wait_rsp(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL bp_rsp got=%h exp=%h", got, exp);
        end
        s0 = n_start;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_mag, rsp_phase, req_ready} !== {1'b1, exp, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%h exp=%h", c,
                         {rsp_valid, rsp_id, rsp_err, rsp_mag, rsp_phase, req_ready}, {1'b1, exp, 4'b0000});
            end
        end
        checks++;
        if (n_start !== s0) begin
            failures++;
            $display("FAIL bp_no_start got=%0d exp=%0d", n_start, s0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, arb_busy} !== 2'b00) begin
            failures++;
            $display("FAIL bp_release got=%b exp=00", {rsp_valid, arb_busy});
        end
    endtask

    task automatic test_timeout();
        logic [NUM_REQ-1:0] rr;
        bit ok;
        rsp_t got, exp;
        int lat;
        core_lat = 0;
        @(negedge clk);
        req_valid = 4'b1011;
        sb.push_back({2'd3, 1'b1, 32'd0, 32'd0});
        wait_grant(rr, ok);
        checks++;
        if (!ok || rr !== 4'b1000) begin
            failures++;
            $display("FAIL to_grant got=%b exp=1000", rr);
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL to_rsp got=%h exp=%h", got, exp);
        end
        checks++;
        if (lat !== TIMEOUT_CYCLES + 2) begin
            failures++;
            $display("FAIL to_latency got=%0d exp=%0d", lat, TIMEOUT_CYCLES + 2);
        end
        core_lat = 5;
        model_mag = 32'd77;
        model_phase = 32'hFFFF_FFFB;
        @(negedge clk);
        req_valid = 4'b0010;
        sb.push_back({2'd1, 1'b0, 32'd77, 32'hFFFF_FFFB});
        wait_grant(rr, ok);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL to_next_rsp got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_collision();
        logic [NUM_REQ-1:0] rr;
        bit ok;
        rsp_t got, exp;
        int lat, s0;
        core_lat = TIMEOUT_CYCLES;
        model_mag = 32'h0000_CAFE;
        model_phase = 32'h0000_1111;
        @(negedge clk);
        req_valid = 4'b0001;
        sb.push_back({2'd0, 1'b0, 32'h0000_CAFE, 32'h0000_1111});
        wait_grant(rr, ok);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL coll_rsp got=%h exp=%h", got, exp);
        end
        core_lat = 2;
        model_mag = 32'd99;
        model_phase = 32'd98;
        @(negedge clk);
        core_busy = 1'b1;
        req_valid = 4'b0010;
        sb.push_back({2'd1, 1'b0, 32'd99, 32'd98});
        wait_grant(rr, ok);
        s0 = n_start;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            checks++;
            if ({core_start, arb_busy} !== 2'b01) begin
                failures++;
                $display("FAIL busy_hold[%0d] got=%b exp=01", c, {core_start, arb_busy});
            end
        end
        core_busy = 1'b0;
        #1;
        checks++;
        if ({core_start, core_x} !== {1'b1, 16'd101}) begin
            failures++;
            $display("FAIL busy_release got=%h exp=%h", {core_start, core_x}, {1'b1, 16'd101});
        end
        wait_rsp(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp || n_start - s0 !== 1) begin
            failures++;
            $display("FAIL busy_rsp got=%h starts=%0d exp=%h starts=1", got, n_start - s0, exp);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [NUM_REQ-1:0] rr;
        bit ok;
        bit bad;
        rsp_t got, exp;
        int lat;
        core_lat = 40;
        model_mag = 32'd55;
        model_phase = 32'd66;
        @(negedge clk);
        req_valid = 4'b0100;
        wait_grant(rr, ok);
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_id, rsp_mag, rsp_phase, core_start, core_x, core_y, arb_busy, req_ready} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0",
                     {rsp_valid, rsp_err, rsp_id, rsp_mag, rsp_phase, core_start, core_x, core_y, arb_busy, req_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid || arb_busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rst_late_done got=activity exp=idle");
        end
        core_lat = 1;
        model_mag = 32'd11;
        model_phase = 32'd22;
        @(negedge clk);
        req_valid = 4'b1111;
        sb.push_back({2'd0, 1'b0, 32'd11, 32'd22});
        wait_grant(rr, ok);
        checks++;
        if (!ok || rr !== 4'b0001) begin
            failures++;
            $display("FAIL rst_next_grant got=%b exp=0001", rr);
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(got, lat, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL rst_next_rsp got=%h exp=%h", got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b1;
        core_busy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_collision();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
